// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - Pipeline hazard, memory-wait and flush sequencing controller
// Mealy outputs from state plus current ID/EX/MEM hazard inputs; ERR is left only by reset.
module hazard_stall_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       id_op_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_branch_taken_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             stall_all_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_next;
    logic            err_set;
    logic            uses_rs2;
    logic            load_use;
    logic            mem_stall;

    always_comb begin
        uses_rs2 = (id_op_i == 7'b0110011) || (id_op_i == 7'b0100011) ||
                   (id_op_i == 7'b1100011);
        load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                   ((ex_rd_i == id_rs1_i) || (uses_rs2 && (ex_rd_i == id_rs2_i)));
        mem_stall = ((state == RUN) && mem_req_i && !mem_ready_i) ||
                    ((state == MEM_WAIT) && !mem_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        err_set    = 1'b0;
        case (state)
            RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_next = MEM_WAIT;
                    wait_next  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next = ERR;
                    wait_next  = '0;
                    err_set    = 1'b1;
                end else begin
                    wait_next = wait_cnt + WC_W'(1);
                end
            end
            ERR:     state_next = ERR;
            default: state_next = RUN;
        endcase
    end

    // Reset forces outputs combinationally so an aborted stall releases at once.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        stall_all_o   = 1'b0;
        if (!rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if ((state == ERR) || mem_stall) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            stall_all_o  = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (id_branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (err_set) begin
                mem_err_o <= 1'b1;
            end
            if (!pc_write_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (ifid_flush_o && (flush_cnt_o != {CNT_W{1'b1}})) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - Directed and random checks of hazard_stall_ctrl against a behavioural model
module tb_hazard_stall_ctrl;

    localparam int MW = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [6:0] id_op;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_branch_taken, ex_memread, mem_req, mem_ready;

    logic        a_pcw, a_ifw, a_fl, a_bub, a_sa, a_err;
    logic [31:0] a_sc, a_fc;
    logic        s_pcw, s_ifw, s_fl, s_bub, s_sa, s_err;
    logic [3:0]  s_sc, s_fc;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: k = consecutive memory-stall cycles so far, err = timed out.
    int          k;
    bit          err;
    longint      sc, fc;
    int          sc4, fc4;
    bit          e_pcw, e_ifw, e_fl, e_bub, e_sa;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(32), .MAX_WAIT(MW)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .id_op_i(id_op), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_branch_taken_i(id_branch_taken), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .pc_write_o(a_pcw), .ifid_write_o(a_ifw),
        .ifid_flush_o(a_fl), .idex_bubble_o(a_bub), .stall_all_o(a_sa), .mem_err_o(a_err),
        .stall_cnt_o(a_sc), .flush_cnt_o(a_fc));

    hazard_stall_ctrl #(.CNT_W(4), .MAX_WAIT(MW)) dut_s (
        .clk_i(clk), .rst_i(rst_i), .id_op_i(id_op), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_branch_taken_i(id_branch_taken), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .pc_write_o(s_pcw), .ifid_write_o(s_ifw),
        .ifid_flush_o(s_fl), .idex_bubble_o(s_bub), .stall_all_o(s_sa), .mem_err_o(s_err),
        .stall_cnt_o(s_sc), .flush_cnt_o(s_fc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_load_use();
        bit r2;
        r2 = (id_op == 7'b0110011) || (id_op == 7'b0100011) || (id_op == 7'b1100011);
        return ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || (r2 && ex_rd == id_rs2));
    endfunction

    task automatic model_outputs();
        bit stall_mem;
        stall_mem = (k > 0 || mem_req) && !mem_ready;
        {e_pcw, e_ifw, e_fl, e_bub, e_sa} = 5'b11000;
        if (err || stall_mem)          {e_pcw, e_ifw, e_fl, e_bub, e_sa} = 5'b00001;
        else if (model_load_use())     {e_pcw, e_ifw, e_fl, e_bub, e_sa} = 5'b00010;
        else if (id_branch_taken)      {e_pcw, e_ifw, e_fl, e_bub, e_sa} = 5'b11100;
    endtask

    task automatic model_update();
        if (!e_pcw) begin
            if (sc < 64'hFFFF_FFFF) sc++;
            if (sc4 < 15) sc4++;
        end
        if (e_fl) begin
            if (fc < 64'hFFFF_FFFF) fc++;
            if (fc4 < 15) fc4++;
        end
        if (!err && (k > 0 || mem_req)) begin
            if (mem_ready) k = 0;
            else begin
                k++;
                if (k == MW + 1) begin
                    err = 1;
                    k   = 0;
                end
            end
        end
    endtask

    task automatic set_idle();
        id_op = 7'b0010011; id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd0;
        id_branch_taken = 0; ex_memread = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Call just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        model_outputs();
        check({tag, ".pc_write"},    a_pcw, e_pcw);
        check({tag, ".ifid_write"},  a_ifw, e_ifw);
        check({tag, ".ifid_flush"},  a_fl,  e_fl);
        check({tag, ".idex_bubble"}, a_bub, e_bub);
        check({tag, ".stall_all"},   a_sa,  e_sa);
        check({tag, ".s_pc_write"},  s_pcw, e_pcw);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".mem_err"},     a_err, err);
        check({tag, ".s_mem_err"},   s_err, err);
        check({tag, ".stall_cnt"},   a_sc, sc[31:0]);
        check({tag, ".flush_cnt"},   a_fc, fc[31:0]);
        check({tag, ".s_stall_cnt"}, s_sc, 32'(sc4));
        check({tag, ".s_flush_cnt"}, s_fc, 32'(fc4));
        @(negedge clk);
    endtask

    task automatic reset_now(input string tag);
        rst_i = 0;
        #1;
        check({tag, ".rst_pc_write"}, {a_pcw, a_ifw, a_fl, a_bub, a_sa}, 5'b00010);
        check({tag, ".rst_err"},      {a_err, s_err}, 2'b00);
        check({tag, ".rst_cnt"},      a_sc | a_fc, 0);
        check({tag, ".rst_s_cnt"},    {s_sc, s_fc}, 0);
        k = 0; err = 0; sc = 0; fc = 0; sc4 = 0; fc4 = 0;
        @(negedge clk);
        rst_i = 1;
    endtask

    logic [6:0] ops [5];

    initial begin
        ops[0] = 7'b0110011; ops[1] = 7'b0100011; ops[2] = 7'b1100011;
        ops[3] = 7'b0010011; ops[4] = 7'b0000011;
        rst_i = 0;
        set_idle();
        @(negedge clk);
        reset_now("init");
        cycle("idle");
        check("idle_pcw_const", a_pcw, 1);

        reset_now("lu");
        ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        cycle("lu_rs1");
        check("lu_stall_cnt_1", a_sc, 1);
        ex_rd = 0; id_rs1 = 0;
        cycle("lu_rd0");
        ex_rd = 5; id_rs1 = 3; id_rs2 = 5;
        cycle("lu_rs2_itype");
        id_op = 7'b0110011;
        cycle("lu_rs2_rtype");
        check("lu_stall_cnt_2", a_sc, 2);

        reset_now("br");
        set_idle();
        id_branch_taken = 1;
        cycle("br_taken");
        check("br_flush_cnt_1", a_fc, 1);
        ex_memread = 1; ex_rd = 7; id_rs1 = 7;
        cycle("br_with_lu");
        check("br_flush_cnt_still_1", a_fc, 1);

        reset_now("mw");
        set_idle();
        mem_req = 1;
        cycle("mw_1");
        ex_memread = 1; ex_rd = 4; id_rs1 = 4;
        cycle("mw_2_lu");
        check("mw_lu_no_bubble", a_bub, 0);
        ex_memread = 0;
        cycle("mw_3");
        mem_ready = 1;
        cycle("mw_ready");
        check("mw_stall_cnt_3", a_sc, 3);
        set_idle();
        cycle("mw_back_run");

        reset_now("to");
        set_idle();
        mem_req = 1;
        for (int i = 0; i < MW + 1; i++) cycle("to_wait");
        check("to_err_set", a_err, 1);
        mem_ready = 1;
        for (int i = 0; i < 3; i++) cycle("to_ready_in_err");
        check("to_err_sticky", a_err, 1);
        reset_now("to_clear");
        set_idle();
        cycle("to_after_reset");

        mem_req = 1;
        cycle("rmw_1");
        cycle("rmw_2");
        #2;
        reset_now("rmw_async");
        set_idle();
        cycle("rmw_release");
        check("rmw_pcw_const", a_pcw, 1);

        reset_now("sat");
        ex_memread = 1; ex_rd = 9; id_rs1 = 9;
        for (int i = 0; i < 20; i++) cycle("sat_hold");
        check("sat_stall_cnt_15", s_sc, 15);
        check("sat_stall_cnt_wide_20", a_sc, 20);

        reset_now("rnd");
        for (int i = 0; i < 500; i++) begin
            id_op           = ops[$urandom_range(0, 4)];
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_memread      = 1'($urandom_range(0, 1));
            id_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset_now("rnd_rst");
            end else begin
                cycle("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
